// File: rtl/id_decode_stage_pkg.sv
// Shared decode encodings for the RV32I/M ID stage: control codes, opcodes and the
// control bundle carried from the combinational decoder into the ID/EX register.
package id_decode_stage_pkg;

    localparam int ALUW_DEF = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] FN7_BASE   = 7'b0000000;
    localparam logic [6:0] FN7_ALT    = 7'b0100000;
    localparam logic [6:0] FN7_MULDIV = 7'b0000001;

    localparam logic [1:0] SRC2_REG   = 2'd0;
    localparam logic [1:0] SRC2_SHAMT = 2'd1;
    localparam logic [1:0] SRC2_IMM   = 2'd2;

    typedef enum logic [2:0] {NOREGWRITE, LB, LH, LW, LBU, LHU} regwrite_t;
    typedef enum logic [2:0] {NOBRANCH, BEQ, BNE, BLT, BLTU, BGE, BGEU} branch_t;
    typedef enum logic [2:0] {RTYPE, ITYPE, STYPE, BTYPE, UTYPE, JTYPE} imm_t;

    typedef enum logic [ALUW_DEF-1:0] {
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLT, ALU_SLTU, ALU_LUI,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_t;

    typedef struct packed {
        logic       jal;
        logic       jalr;
        logic       mem_to_reg;
        logic       load_npc;
        logic       alu_src1;
        regwrite_t  reg_write;
        logic [3:0] mem_write;
        logic [1:0] reg_read;
        branch_t    branch_type;
        alu_t       alu_ctrl;
        logic [1:0] alu_src2;
        imm_t       imm_type;
        logic       is_muldiv;
        logic       is_div;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/id_decode_stage_if.sv
// IF/ID-side inputs and ID/EX-side control outputs of the decode stage.
interface id_decode_stage_if #(parameter int ALUW = 5);

    logic [31:0]     instr_i;
    logic [31:0]     pc_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic            flush_i;
    logic            out_ready_i;
    logic            out_valid_o;
    logic            jal_o;
    logic            jalr_o;
    logic            mem_to_reg_o;
    logic            load_npc_o;
    logic            alu_src1_o;
    logic [2:0]      reg_write_o;
    logic [3:0]      mem_write_o;
    logic [1:0]      reg_read_o;
    logic [2:0]      branch_type_o;
    logic [ALUW-1:0] alu_ctrl_o;
    logic [1:0]      alu_src2_o;
    logic [2:0]      imm_type_o;
    logic            is_muldiv_o;
    logic [31:0]     pc_o;
    logic            illegal_o;
    logic            illegal_sticky_o;
    logic [31:0]     illegal_pc_o;
    logic            illegal_clr_i;
    logic            muldiv_busy_o;

    modport master (
        output instr_i, pc_i, in_valid_i, flush_i, out_ready_i, illegal_clr_i,
        input  in_ready_o, out_valid_o, jal_o, jalr_o, mem_to_reg_o, load_npc_o,
               alu_src1_o, reg_write_o, mem_write_o, reg_read_o, branch_type_o,
               alu_ctrl_o, alu_src2_o, imm_type_o, is_muldiv_o, pc_o, illegal_o,
               illegal_sticky_o, illegal_pc_o, muldiv_busy_o
    );

    modport slave (
        input  instr_i, pc_i, in_valid_i, flush_i, out_ready_i, illegal_clr_i,
        output in_ready_o, out_valid_o, jal_o, jalr_o, mem_to_reg_o, load_npc_o,
               alu_src1_o, reg_write_o, mem_write_o, reg_read_o, branch_type_o,
               alu_ctrl_o, alu_src2_o, imm_type_o, is_muldiv_o, pc_o, illegal_o,
               illegal_sticky_o, illegal_pc_o, muldiv_busy_o
    );

endinterface

// File: rtl/id_decode_stage_comb.sv
// Pure combinational RV32I/M decoder; illegal encodings collapse to a NOP bundle
// with only the illegal bit set.
module id_decode_comb
    import id_decode_stage_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0] opcode_i,
    input  logic [2:0] fn3_i,
    input  logic [6:0] fn7_i,
    output ctrl_t      ctrl_o
);

    ctrl_t dec;
    logic  bad;

    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (opcode_i)
            OP_LUI: begin
                dec.reg_write = LW;
                dec.alu_ctrl  = ALU_LUI;
                dec.alu_src2  = SRC2_IMM;
                dec.imm_type  = UTYPE;
            end
            OP_AUIPC: begin
                dec.reg_write = LW;
                dec.alu_ctrl  = ALU_ADD;
                dec.alu_src1  = 1'b1;
                dec.alu_src2  = SRC2_IMM;
                dec.imm_type  = UTYPE;
            end
            OP_JAL: begin
                dec.jal       = 1'b1;
                dec.load_npc  = 1'b1;
                dec.reg_write = LW;
                dec.alu_ctrl  = ALU_ADD;
                dec.alu_src1  = 1'b1;
                dec.alu_src2  = SRC2_IMM;
                dec.imm_type  = JTYPE;
            end
            OP_JALR: begin
                dec.jalr      = 1'b1;
                dec.load_npc  = 1'b1;
                dec.reg_write = LW;
                dec.reg_read  = 2'b10;
                dec.alu_ctrl  = ALU_ADD;
                dec.alu_src2  = SRC2_IMM;
                dec.imm_type  = ITYPE;
                bad           = (fn3_i != 3'b000);
            end
            OP_BRANCH: begin
                dec.reg_read = 2'b11;
                dec.alu_ctrl = ALU_ADD;
                dec.imm_type = BTYPE;
                case (fn3_i)
                    3'b000:  dec.branch_type = BEQ;
                    3'b001:  dec.branch_type = BNE;
                    3'b100:  dec.branch_type = BLT;
                    3'b101:  dec.branch_type = BGE;
                    3'b110:  dec.branch_type = BLTU;
                    3'b111:  dec.branch_type = BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.mem_to_reg = 1'b1;
                dec.reg_read   = 2'b10;
                dec.alu_ctrl   = ALU_ADD;
                dec.alu_src2   = SRC2_IMM;
                dec.imm_type   = ITYPE;
                case (fn3_i)
                    3'b000:  dec.reg_write = LB;
                    3'b001:  dec.reg_write = LH;
                    3'b010:  dec.reg_write = LW;
                    3'b100:  dec.reg_write = LBU;
                    3'b101:  dec.reg_write = LHU;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.reg_read = 2'b11;
                dec.alu_ctrl = ALU_ADD;
                dec.alu_src2 = SRC2_IMM;
                dec.imm_type = STYPE;
                case (fn3_i)
                    3'b000:  dec.mem_write = 4'b0001;
                    3'b001:  dec.mem_write = 4'b0011;
                    3'b010:  dec.mem_write = 4'b1111;
                    default: bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.reg_write = LW;
                dec.reg_read  = 2'b10;
                dec.alu_src2  = SRC2_IMM;
                dec.imm_type  = ITYPE;
                case (fn3_i)
                    3'b000: dec.alu_ctrl = ALU_ADD;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b011: dec.alu_ctrl = ALU_SLTU;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b001: begin
                        dec.alu_ctrl = ALU_SLL;
                        dec.alu_src2 = SRC2_SHAMT;
                        bad          = (fn7_i != FN7_BASE);
                    end
                    3'b101: begin
                        dec.alu_ctrl = (fn7_i == FN7_ALT) ? ALU_SRA : ALU_SRL;
                        dec.alu_src2 = SRC2_SHAMT;
                        bad          = (fn7_i != FN7_BASE) && (fn7_i != FN7_ALT);
                    end
                    default: dec.alu_ctrl = ALU_AND;
                endcase
            end
            OP_REG: begin
                dec.reg_write = LW;
                dec.reg_read  = 2'b11;
                dec.alu_src2  = SRC2_REG;
                dec.imm_type  = RTYPE;
                if (fn7_i == FN7_BASE) begin
                    case (fn3_i)
                        3'b000:  dec.alu_ctrl = ALU_ADD;
                        3'b001:  dec.alu_ctrl = ALU_SLL;
                        3'b010:  dec.alu_ctrl = ALU_SLT;
                        3'b011:  dec.alu_ctrl = ALU_SLTU;
                        3'b100:  dec.alu_ctrl = ALU_XOR;
                        3'b101:  dec.alu_ctrl = ALU_SRL;
                        3'b110:  dec.alu_ctrl = ALU_OR;
                        default: dec.alu_ctrl = ALU_AND;
                    endcase
                end else if (fn7_i == FN7_ALT) begin
                    case (fn3_i)
                        3'b000:  dec.alu_ctrl = ALU_SUB;
                        3'b101:  dec.alu_ctrl = ALU_SRA;
                        default: bad = 1'b1;
                    endcase
                end else if (ENABLE_M && (fn7_i == FN7_MULDIV)) begin
                    dec.is_muldiv = 1'b1;
                    dec.is_div    = fn3_i[2];
                    case (fn3_i)
                        3'b000:  dec.alu_ctrl = ALU_MUL;
                        3'b001:  dec.alu_ctrl = ALU_MULH;
                        3'b010:  dec.alu_ctrl = ALU_MULHSU;
                        3'b011:  dec.alu_ctrl = ALU_MULHU;
                        3'b100:  dec.alu_ctrl = ALU_DIV;
                        3'b101:  dec.alu_ctrl = ALU_DIVU;
                        3'b110:  dec.alu_ctrl = ALU_REM;
                        default: dec.alu_ctrl = ALU_REMU;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            ctrl_o         = '0;
            ctrl_o.illegal = 1'b1;
        end else begin
            ctrl_o = dec;
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered ID stage: ID/EX control register behind valid/ready, MUL/DIV issue
// sequencer holding off new instructions while EX is occupied, sticky illegal trap.
//   state     | meaning
//   S_IDLE    | accepting instructions normally
//   S_MD_WAIT | M op issued to EX; counting down its remaining occupancy
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned MUL_LAT  = 2,
    parameter int unsigned DIV_LAT  = 33,
    parameter int          ALUW     = ALUW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    id_decode_stage_if.slave bus
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MD_WAIT = 1'b1;

    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

    ctrl_t       dec;
    ctrl_t       bundle_q, bundle_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sticky_q, sticky_d;
    logic [31:0] ill_pc_q, ill_pc_d;

    logic        in_ready;
    logic        load;
    logic        md_go;
    logic [7:0]  md_cnt;
    logic        unused_instr;

    id_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
        .opcode_i (bus.instr_i[6:0]),
        .fn3_i    (bus.instr_i[14:12]),
        .fn7_i    (bus.instr_i[31:25]),
        .ctrl_o   (dec)
    );

    assign unused_instr = ^{bus.instr_i[24:15], bus.instr_i[11:7]};

    // A held M op must reach EX and start its wait before anything new is taken.
    assign in_ready = (state_q == S_IDLE) &
                      (~valid_q | (bus.out_ready_i & ~bundle_q.is_muldiv));
    assign load     = bus.in_valid_i & in_ready & ~bus.flush_i;
    assign md_go    = valid_q & bus.out_ready_i & bundle_q.is_muldiv;
    assign md_cnt   = bundle_q.is_div ? DIV_CNT : MUL_CNT;

    always_comb begin
        bundle_d = bundle_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            if (load) begin
                bundle_d = dec;
                pc_d     = bus.pc_i;
                valid_d  = 1'b1;
            end else if (valid_q & bus.out_ready_i) begin
                valid_d = 1'b0;
            end

            if (state_q == S_IDLE) begin
                if (md_go && (md_cnt != 8'd0)) begin
                    state_d = S_MD_WAIT;
                    cnt_d   = md_cnt;
                end
            end else begin
                if (cnt_q == 8'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        end
    end

    // A new illegal in the same cycle as a clear re-arms the trap with the new PC.
    always_comb begin
        sticky_d = sticky_q;
        ill_pc_d = ill_pc_q;
        if (load && dec.illegal && (~sticky_q || bus.illegal_clr_i)) begin
            sticky_d = 1'b1;
            ill_pc_d = bus.pc_i;
        end else if (bus.illegal_clr_i) begin
            sticky_d = 1'b0;
            ill_pc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= '0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            ill_pc_q <= '0;
        end else begin
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            ill_pc_q <= ill_pc_d;
        end
    end

    assign bus.in_ready_o       = in_ready;
    assign bus.out_valid_o      = valid_q;
    assign bus.jal_o            = bundle_q.jal;
    assign bus.jalr_o           = bundle_q.jalr;
    assign bus.mem_to_reg_o     = bundle_q.mem_to_reg;
    assign bus.load_npc_o       = bundle_q.load_npc;
    assign bus.alu_src1_o       = bundle_q.alu_src1;
    assign bus.reg_write_o      = bundle_q.reg_write;
    assign bus.mem_write_o      = bundle_q.mem_write;
    assign bus.reg_read_o       = bundle_q.reg_read;
    assign bus.branch_type_o    = bundle_q.branch_type;
    assign bus.alu_ctrl_o       = ALUW'(bundle_q.alu_ctrl);
    assign bus.alu_src2_o       = bundle_q.alu_src2;
    assign bus.imm_type_o       = bundle_q.imm_type;
    assign bus.is_muldiv_o      = bundle_q.is_muldiv;
    assign bus.pc_o             = pc_q;
    assign bus.illegal_o        = bundle_q.illegal;
    assign bus.illegal_sticky_o = sticky_q;
    assign bus.illegal_pc_o     = ill_pc_q;
    assign bus.muldiv_busy_o    = (state_q == S_MD_WAIT);

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: pipeline flow, back-pressure, MUL/DIV gaps,
// flush, illegal trapping (with and without the M extension) and async reset.
module tb_id_decode_stage;

    localparam logic [4:0] A_ADD = 5'd3;
    localparam logic [4:0] A_SUB = 5'd4;
    localparam logic [4:0] A_MUL = 5'd11;
    localparam logic [4:0] A_DIV = 5'd15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n;
    logic gap_ok;

    always #5 clk = ~clk;

    id_decode_stage_if #(.ALUW(5)) bus ();
    id_decode_stage_if #(.ALUW(5)) nm ();

    id_decode_stage #(.ENABLE_M(1'b1), .MUL_LAT(2), .DIV_LAT(33), .ALUW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    id_decode_stage #(.ENABLE_M(1'b0), .MUL_LAT(2), .DIV_LAT(33), .ALUW(5)) dut_nm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (nm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.instr_i = '0; bus.pc_i = '0; bus.in_valid_i = 0; bus.flush_i = 0;
        bus.out_ready_i = 1; bus.illegal_clr_i = 0;
        nm.instr_i = '0; nm.pc_i = '0; nm.in_valid_i = 0; nm.flush_i = 0;
        nm.out_ready_i = 1; nm.illegal_clr_i = 0;

        // reset state
        #12;
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_reg_write", bus.reg_write_o, 0);
        chk("rst_mem_write", bus.mem_write_o, 0);
        chk("rst_branch", bus.branch_type_o, 0);
        chk("rst_alu", bus.alu_ctrl_o, 0);
        chk("rst_pc", bus.pc_o, 0);
        chk("rst_sticky", bus.illegal_sticky_o, 0);
        chk("rst_ill_pc", bus.illegal_pc_o, 0);
        chk("rst_busy", bus.muldiv_busy_o, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("idle_in_ready", bus.in_ready_o, 1);

        // add then sub back to back
        bus.instr_i = 32'h002081B3; bus.pc_i = 32'h0; bus.in_valid_i = 1;
        tick();
        chk("add_valid", bus.out_valid_o, 1);
        chk("add_alu", bus.alu_ctrl_o, A_ADD);
        chk("add_reg_read", bus.reg_read_o, 2'b11);
        chk("add_reg_write", bus.reg_write_o, 3);
        chk("add_pc", bus.pc_o, 32'h0);
        chk("add_illegal", bus.illegal_o, 0);
        bus.instr_i = 32'h402081B3; bus.pc_i = 32'h4;
        #1 chk("add_in_ready", bus.in_ready_o, 1);
        tick();
        chk("sub_valid", bus.out_valid_o, 1);
        chk("sub_alu", bus.alu_ctrl_o, A_SUB);
        chk("sub_pc", bus.pc_o, 32'h4);
        bus.in_valid_i = 0;
        tick();
        chk("drain_valid", bus.out_valid_o, 0);
        chk("drain_hold_alu", bus.alu_ctrl_o, A_SUB);

        // lw under back-pressure
        bus.instr_i = 32'h0040A283; bus.pc_i = 32'h8; bus.in_valid_i = 1; bus.out_ready_i = 0;
        tick();
        bus.in_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("lw_valid", bus.out_valid_o, 1);
            chk("lw_mem_to_reg", bus.mem_to_reg_o, 1);
            chk("lw_reg_write", bus.reg_write_o, 3);
            chk("lw_imm", bus.imm_type_o, 1);
            chk("lw_pc", bus.pc_o, 32'h8);
            #1 chk("lw_in_ready", bus.in_ready_o, 0);
            tick();
        end
        bus.out_ready_i = 1;
        #1 chk("lw_release_ready", bus.in_ready_o, 1);
        tick();
        chk("lw_drained", bus.out_valid_o, 0);

        // mul then div issue gaps
        bus.instr_i = 32'h022081B3; bus.pc_i = 32'h10; bus.in_valid_i = 1;
        tick();
        chk("mul_alu", bus.alu_ctrl_o, A_MUL);
        chk("mul_is_muldiv", bus.is_muldiv_o, 1);
        bus.instr_i = 32'h0220C1B3; bus.pc_i = 32'h14;
        #1 chk("mul_held_ready", bus.in_ready_o, 0);
        tick();
        chk("mul_gap_busy", bus.muldiv_busy_o, 1);
        chk("mul_gap_valid", bus.out_valid_o, 0);
        #1 chk("mul_gap_ready", bus.in_ready_o, 0);
        tick();
        chk("mul_done_busy", bus.muldiv_busy_o, 0);
        chk("mul_done_ready", bus.in_ready_o, 1);
        tick();
        chk("div_valid", bus.out_valid_o, 1);
        chk("div_alu", bus.alu_ctrl_o, A_DIV);
        chk("div_pc", bus.pc_o, 32'h14);
        bus.in_valid_i = 0;
        tick();
        n = 0; gap_ok = 1;
        while (bus.muldiv_busy_o && n < 100) begin
            if (bus.in_ready_o !== 1'b0) gap_ok = 0;
            n++;
            tick();
        end
        chk("div_gap_len", n, 32);
        chk("div_gap_ready_low", gap_ok, 1);
        chk("div_done_ready", bus.in_ready_o, 1);

        // flush at counter=20 in a div wait, then flush suppressing a load
        bus.instr_i = 32'h0220C1B3; bus.pc_i = 32'h18; bus.in_valid_i = 1;
        tick();
        bus.in_valid_i = 0;
        tick();
        chk("flush_pre_busy", bus.muldiv_busy_o, 1);
        repeat (12) tick();
        bus.flush_i = 1;
        tick();
        bus.flush_i = 0;
        chk("flush_busy", bus.muldiv_busy_o, 0);
        chk("flush_valid", bus.out_valid_o, 0);
        #1 chk("flush_ready", bus.in_ready_o, 1);
        bus.instr_i = 32'h002081B3; bus.pc_i = 32'h1C; bus.in_valid_i = 1; bus.flush_i = 1;
        tick();
        chk("flush_kills_load", bus.out_valid_o, 0);
        bus.flush_i = 0; bus.in_valid_i = 0;

        // bne and an illegal R-type on the M-enabled stage
        bus.instr_i = 32'h00209463; bus.pc_i = 32'h3C; bus.in_valid_i = 1;
        tick();
        chk("bne_branch", bus.branch_type_o, 2);
        chk("bne_imm", bus.imm_type_o, 3);
        chk("bne_reg_write", bus.reg_write_o, 0);
        bus.instr_i = 32'h402091B3; bus.pc_i = 32'h40;
        tick();
        chk("alt_fn3_illegal", bus.illegal_o, 1);
        chk("alt_fn3_reg_write", bus.reg_write_o, 0);
        chk("alt_fn3_branch", bus.branch_type_o, 0);
        chk("alt_fn3_sticky", bus.illegal_sticky_o, 1);
        chk("alt_fn3_ill_pc", bus.illegal_pc_o, 32'h40);
        bus.in_valid_i = 0;
        tick();

        // ENABLE_M=0: mul is illegal; sticky keeps the first PC
        nm.instr_i = 32'h022081B3; nm.pc_i = 32'h100; nm.in_valid_i = 1;
        tick();
        chk("nm_valid", nm.out_valid_o, 1);
        chk("nm_illegal", nm.illegal_o, 1);
        chk("nm_reg_write", nm.reg_write_o, 0);
        chk("nm_mem_write", nm.mem_write_o, 0);
        chk("nm_branch", nm.branch_type_o, 0);
        chk("nm_jal", nm.jal_o, 0);
        chk("nm_jalr", nm.jalr_o, 0);
        chk("nm_is_muldiv", nm.is_muldiv_o, 0);
        chk("nm_sticky", nm.illegal_sticky_o, 1);
        chk("nm_ill_pc", nm.illegal_pc_o, 32'h100);
        nm.instr_i = 32'hFFFFFFFF; nm.pc_i = 32'h104;
        tick();
        chk("nm_second_illegal", nm.illegal_o, 1);
        chk("nm_second_pc_o", nm.pc_o, 32'h104);
        chk("nm_ill_pc_kept", nm.illegal_pc_o, 32'h100);
        nm.in_valid_i = 0; nm.illegal_clr_i = 1;
        tick();
        nm.illegal_clr_i = 0;
        chk("nm_clr_sticky", nm.illegal_sticky_o, 0);
        chk("nm_clr_pc", nm.illegal_pc_o, 0);
        nm.instr_i = 32'hFFFFFFFF; nm.pc_i = 32'h10C; nm.in_valid_i = 1;
        tick();
        chk("nm_rearm_pc", nm.illegal_pc_o, 32'h10C);
        nm.pc_i = 32'h110; nm.illegal_clr_i = 1;
        tick();
        chk("nm_clr_vs_new_sticky", nm.illegal_sticky_o, 1);
        chk("nm_clr_vs_new_pc", nm.illegal_pc_o, 32'h110);
        nm.in_valid_i = 0; nm.illegal_clr_i = 0;

        // async reset in the middle of a div wait with sb pending
        bus.instr_i = 32'h0220C1B3; bus.pc_i = 32'h50; bus.in_valid_i = 1;
        tick();
        bus.in_valid_i = 0;
        tick();
        repeat (3) tick();
        chk("rst_mid_busy_pre", bus.muldiv_busy_o, 1);
        bus.instr_i = 32'h00208023; bus.pc_i = 32'h20; bus.in_valid_i = 1;
        #1 chk("rst_mid_ready_pre", bus.in_ready_o, 0);
        rst_n = 0;
        #1;
        chk("rst_mid_valid", bus.out_valid_o, 0);
        chk("rst_mid_busy", bus.muldiv_busy_o, 0);
        chk("rst_mid_alu", bus.alu_ctrl_o, 0);
        chk("rst_mid_pc", bus.pc_o, 0);
        chk("rst_mid_is_muldiv", bus.is_muldiv_o, 0);
        chk("rst_mid_sticky", bus.illegal_sticky_o, 0);
        chk("rst_mid_ill_pc", bus.illegal_pc_o, 0);
        #1 rst_n = 1;
        tick();
        chk("sb_valid", bus.out_valid_o, 1);
        chk("sb_mem_write", bus.mem_write_o, 4'b0001);
        chk("sb_imm", bus.imm_type_o, 2);
        chk("sb_reg_read", bus.reg_read_o, 2'b11);
        chk("sb_pc", bus.pc_o, 32'h20);
        bus.in_valid_i = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered RV32I/M instruction-decode stage for the pipelined CPU; successor to the combinational decoder.
- Decodes the IF/ID instruction into the same control bundle, plus M-extension ALU ops, illegal-instruction detection and a multi-cycle MUL/DIV issue sequencer.
- Drives the ID/EX control register behind a valid/ready handshake.

Parameters:
- ENABLE_M, 1, 1 decodes MUL/DIV/REM ops; 0 flags them illegal.
- MUL_LAT, 2, EX occupancy in cycles for the MUL class (range 1..255).
- DIV_LAT, 33, EX occupancy in cycles for the DIV/REM class (range 1..255).
- ALUW, 5, AluContrl width (widened from 4 to hold M ops).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_i  in  32  instruction from IF/ID
- pc_i  in  32  PC of instr_i
- in_valid_i  in  1  instr_i valid
- in_ready_o  out  1  stage can accept
- flush_i  in  1  kill held and in-flight decode (branch/jump redirect)
- out_ready_i  in  1  EX accepts bundle
- out_valid_o  out  1  bundle valid
- jal_o, jalr_o, mem_to_reg_o, load_npc_o, alu_src1_o  out  1 each  as in the existing decoder
- reg_write_o  out  3  register write mode
- mem_write_o  out  4  byte-write mask
- reg_read_o  out  2  [1]=rs1 used, [0]=rs2 used
- branch_type_o  out  3  branch type
- alu_ctrl_o  out  ALUW  ALU function
- alu_src2_o  out  2  ALU src2 select
- imm_type_o  out  3  immediate format
- is_muldiv_o  out  1  bundle holds an M op
- pc_o  out  32  registered pc_i
- illegal_o  out  1  bundle is an illegal instruction (qualified by out_valid_o)
- illegal_sticky_o  out  1  set on first illegal; cleared by illegal_clr_i
- illegal_pc_o  out  32  PC of the first illegal instruction since the last clear
- illegal_clr_i  in  1  clears sticky flag and PC
- muldiv_busy_o  out  1  FSM in MD_WAIT

Behaviour:
- Reset (async, rst_n=0): every output register is 0. out_valid_o=0, bundle all zero (NOREGWRITE, mask 0000, NOBRANCH), illegal_sticky_o=0, illegal_pc_o=0, FSM=IDLE, counter=0.
- Decode is combinational from instr_i. Opcode/fn3/fn7 mapping for RV32I is identical to the existing decoder.
- Latency: an instruction accepted at edge t appears on the outputs after edge t.
- in_ready_o = (state==IDLE) & (~out_valid_o | (out_ready_i & ~is_muldiv_o)).
  - A held M op therefore blocks co-acceptance of the next instruction.
- Load when in_valid_i & in_ready_o: capture bundle and pc_i; set out_valid_o=1.
- Drain when out_valid_o & out_ready_i with no load: clear out_valid_o. Bundle fields hold their values.
- Bundle is stable while out_valid_o & ~out_ready_i.
- FSM IDLE -> MD_WAIT: when an M op is accepted downstream (out_valid_o & out_ready_i & is_muldiv_o) and its LAT>1.
  - Counter loads LAT-1; LAT is MUL_LAT for fn3[2]=0, DIV_LAT for fn3[2]=1.
  - If LAT==1, the FSM stays in IDLE.
- MD_WAIT: counter decrements each cycle; at counter==1 the next state is IDLE.
  - in_ready_o=0 for exactly LAT-1 cycles after the acceptance cycle.
- flush_i has highest priority. At the next edge: out_valid_o=0, FSM=IDLE, counter=0, and no load that cycle.
  - Sticky illegal state is not affected by flush_i.
- Illegal instructions:
  - Unknown opcode.
  - Load fn3 in {011,110,111}.
  - Store fn3 >2.
  - Branch fn3 in {010,011}.
  - JALR fn3!=0.
  - R-type fn7 not in {0000000, 0100000, 0000001 when ENABLE_M}.
  - fn7=0100000 with fn3 not in {000,101}.
  - SLLI with fn7!=0.
  - SRLI/SRAI with fn7 not in {0000000,0100000}.
- An illegal instruction loads as a NOP bundle (reg_write=NOREGWRITE, mem_write=0000, NOBRANCH, jal/jalr=0) with illegal_o=1.
- illegal_sticky_o and illegal_pc_o are set/captured only when illegal_sticky_o is 0.
  - Same-cycle clear and new illegal: the new illegal wins.
- Simultaneous load and drain is a normal pipeline advance.

Decomposition:
- Shared package/header (extend the existing parameters file) holds:
  - RegWrite modes, BranchType codes, ImmType codes.
  - ALU codes widened to ALUW, with new MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Opcode constants.
- One sub-module: id_decode_comb, the pure combinational decoder, which also outputs illegal and is_muldiv.
- The stage wrapper holds the register, handshake, FSM and sticky logic.

Test Plan:
- add 0x002081B3 then sub 0x402081B3, out_ready_i=1 -> consecutive bundles with alu_ctrl ADD then SUB, reg_read 11, 1-cycle latency, in_ready_o held at 1.
- lw 0x0040A283 with out_ready_i=0 for 3 cycles -> bundle held stable (mem_to_reg=1, reg_write=LW, imm ITYPE); in_ready_o=0 until release.
- mul 0x022081B3 (MUL_LAT=2) followed by div 0x0220C1B3 (DIV_LAT=33):
  - Gap of 1 cycle of in_ready_o=0 after the mul is accepted.
  - Gap of 32 cycles after the div is accepted.
  - muldiv_busy_o=1 during each gap.
- ENABLE_M=0 with 0x022081B3 at pc 0x100 -> illegal_o=1, NOP bundle, illegal_sticky_o=1, illegal_pc_o=0x100.
  - A second illegal 0xFFFFFFFF at pc 0x104 leaves illegal_pc_o=0x100.
  - illegal_clr_i clears both.
- flush_i asserted at counter=20 during a div wait -> next cycle FSM=IDLE, out_valid_o=0, in_ready_o=1.
- rst_n pulsed low mid-MD_WAIT with sb 0x00208023 held -> all outputs 0 immediately (asynchronous); after release, sb decodes to mem_write=0001.
